// File: rtl/data_upsizer_pkg.sv
// data_upsizer_pkg
// Shared width helpers and limits for the data_upsizer stream stage.
//   lane_idx_w(n) : bits needed for a lane index 0..n-1
//   lane_cnt_w(n) : bits needed for a lane count 0..n
//   UPSIZER_N_MAX : largest supported beats-per-word
package data_upsizer_pkg;

  localparam int UPSIZER_N_MAX = 16;

  function automatic int lane_idx_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int lane_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/upsizer_out_reg.sv
// upsizer_out_reg
// Output register of the upsizer: holds one completed wide payload and its
// valid flag. A load takes priority over a pop, so a word can be popped and
// replaced in the same cycle without a bubble.
// Ports:
//   clk      : clock
//   rst      : synchronous active-low reset
//   load     : capture payload_in, set valid
//   pop      : downstream took the word, clear valid (unless loading)
//   payload_in [W-1:0] : next word to hold
//   valid    : a word is held
//   payload  [W-1:0] : held word, stable while not loaded
module upsizer_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         pop,
  input  logic [W-1:0] payload_in,
  output logic         valid,
  output logic [W-1:0] payload
);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid   <= 1'b0;
      payload <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      payload <= payload_in;
    end else if (pop) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/data_upsizer.sv
// data_upsizer
// Collects N consecutive L-bit beats from a valid/ready source and emits them
// as one N*L-bit word on a valid/ready sink. The first beat of a word lands in
// the least significant lane. Lanes 0..N-2 are always accepted; only the beat
// that completes a word can stall, and only while a previous word is still
// held by the downstream.
// Optional feature: define DATA_UPSIZER_FLUSH_EN to add last_f / lanes_b,
// which let a packet end close a partially filled word (upper lanes zero).
// Ports:
//   clk, rst (synchronous active-low)
//   valid_f, ready_f, data_f[L-1:0]   : narrow input stream
//   last_f                            : packet end (flush build only)
//   valid_b, ready_b, data_b[N*L-1:0] : wide output stream
//   lanes_b[$clog2(N+1)-1:0]          : filled lanes (flush build only)
module data_upsizer
  import data_upsizer_pkg::*;
#(
  parameter int L = 8,
  parameter int N = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_f,
  output logic                      ready_f,
  input  logic [L-1:0]              data_f,
`ifdef DATA_UPSIZER_FLUSH_EN
  input  logic                      last_f,
  output logic [lane_cnt_w(N)-1:0]  lanes_b,
`endif
  output logic                      valid_b,
  input  logic                      ready_b,
  output logic [N*L-1:0]            data_b
);

  localparam int IW = lane_idx_w(N);
  localparam int CW = lane_cnt_w(N);

  logic [IW-1:0]  idx;
  logic [N*L-1:0] acc;
  logic [N*L-1:0] word_next;
  logic           last_lane;
  logic           xfer_f;
  logic           complete;

  assign last_lane = (idx == IW'(N - 1));

`ifdef DATA_UPSIZER_FLUSH_EN
  // A beat flagged last completes the word wherever it lands, so it may stall
  // just like the beat in the top lane.
  assign ready_f  = (!last_lane && !(valid_f && last_f)) || !valid_b || ready_b;
  assign complete = xfer_f && (last_lane || last_f);
`else
  assign ready_f  = !last_lane || !valid_b || ready_b;
  assign complete = xfer_f && last_lane;
`endif

  assign xfer_f = valid_f && ready_f;

  // Current accumulator with the incoming beat merged into lane idx. Lanes
  // above idx are still zero because acc clears whenever a word completes.
  // NOTE: every always_comb output is assigned a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    word_next = acc;
    for (int k = 0; k < N; k++) begin
      if (idx == IW'(k)) word_next[k*L +: L] = data_f;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx <= '0;
      acc <= '0;
    end else if (xfer_f) begin
      if (complete) begin
        idx <= '0;
        acc <= '0;
      end else begin
        idx <= idx + 1'b1;
        acc <= word_next;
      end
    end
  end

  // The lane count travels with the data inside the output register so both
  // stay stable together while the downstream stalls.
`ifdef DATA_UPSIZER_FLUSH_EN
  localparam int PW = N*L + CW;
  logic [CW-1:0] lanes_next;
  assign lanes_next = CW'(idx) + CW'(1);
`else
  localparam int PW = N*L;
`endif

  logic [PW-1:0] payload_in;
  logic [PW-1:0] payload_q;

`ifdef DATA_UPSIZER_FLUSH_EN
  assign payload_in        = {lanes_next, word_next};
  assign {lanes_b, data_b} = payload_q;
`else
  assign payload_in = word_next;
  assign data_b     = payload_q;
`endif

  upsizer_out_reg #(
    .W (PW)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (complete),
    .pop        (valid_b && ready_b),
    .payload_in (payload_in),
    .valid      (valid_b),
    .payload    (payload_q)
  );

endmodule

// File: tb/tb_data_upsizer.sv
// tb_data_upsizer
// Drives data_upsizer (L=8, N=4) with directed and random streams and compares
// every cycle against a packet-level model: a list of accepted beats and a
// queue of expected words. Build with DATA_UPSIZER_FLUSH_EN to cover flush.
module tb_data_upsizer;

  localparam int L = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           valid_f = 1'b0;
  logic           ready_b = 1'b0;
  logic [L-1:0]   data_f = '0;
  logic           ready_f;
  logic           valid_b;
  logic [N*L-1:0] data_b;
`ifdef DATA_UPSIZER_FLUSH_EN
  logic           last_f = 1'b0;
  logic [2:0]     lanes_b;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0]  beats[$];
  logic [31:0] exp_w[$];
  int          exp_l[$];

  always #5 clk = ~clk;

  data_upsizer #(.L(L), .N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_f (valid_f),
    .ready_f (ready_f),
    .data_f  (data_f),
`ifdef DATA_UPSIZER_FLUSH_EN
    .last_f  (last_f),
    .lanes_b (lanes_b),
`endif
    .valid_b (valid_b),
    .ready_b (ready_b),
    .data_b  (data_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_beats();
    logic [31:0] w = '0;
    for (int k = 0; k < beats.size(); k++) w = w + (32'(beats[k]) << (8 * k));
    return w;
  endfunction

  // One clock cycle: check outputs against the model, drive inputs, check
  // ready_f, then advance the model for the coming rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic last, input logic rb);
    logic exp_rdy;
    logic eff_last;
    @(negedge clk);
    check("valid_b", valid_b, exp_w.size() != 0);
    if (exp_w.size() != 0) begin
      check("data_b", data_b, exp_w[0]);
`ifdef DATA_UPSIZER_FLUSH_EN
      check("lanes_b", lanes_b, exp_l[0]);
`endif
    end
    valid_f = v;
    data_f  = d;
    ready_b = rb;
`ifdef DATA_UPSIZER_FLUSH_EN
    last_f   = last;
    eff_last = last;
`else
    eff_last = 1'b0;
`endif
    #1;
    exp_rdy = (beats.size() != N - 1 && !(v && eff_last)) || exp_w.size() == 0 || rb;
    check("ready_f", ready_f, exp_rdy);
    if (exp_w.size() != 0 && rb) begin
      void'(exp_w.pop_front());
      void'(exp_l.pop_front());
    end
    if (v && exp_rdy) begin
      beats.push_back(d);
      if (beats.size() == N || eff_last) begin
        exp_w.push_back(pack_beats());
        exp_l.push_back(beats.size());
        beats.delete();
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    valid_f = 1'b0;
    ready_b = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    beats.delete();
    exp_w.delete();
    exp_l.delete();
    check("rst_valid_b", valid_b, 0);
    check("rst_data_b", data_b, 0);
    check("rst_ready_f", ready_f, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] basic[4];
    basic = '{8'h11, 8'h22, 8'h33, 8'h44};

    do_reset();

    // Basic packing: expect 0x44332211 one cycle after the 0x44 transfer.
    foreach (basic[i]) step(1'b1, basic[i], 1'b0, 1'b1);
    idle(2);

    // Streaming 0x00..0x0F back to back.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
    idle(2);

    // Back-pressure: first word stalls, 3 more beats accepted, then stall,
    // and the stalled beat goes in when ready_b rises (pop + load together).
    for (int i = 0; i < 4; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    idle(3);

    // Reset mid-word, then a fresh word.
    step(1'b1, 8'hE1, 1'b0, 1'b1);
    step(1'b1, 8'hE2, 1'b0, 1'b1);
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b1);
    idle(2);

    // Reset while an output word is stalled drops it.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    do_reset();
    idle(2);

`ifdef DATA_UPSIZER_FLUSH_EN
    // Flush: 0x55, 0x66(last) -> 0x00006655 with 2 lanes, next word at lane 0.
    step(1'b1, 8'h55, 1'b0, 1'b1);
    step(1'b1, 8'h66, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b1);
    idle(2);
`endif

    // Random traffic with random back-pressure.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 5) == 0, ($urandom % 3) != 0);
    end
    idle(4);
    check("drained", exp_w.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
